// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding,
// the default operand width and a constant-function counter sizer.
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   // Never returns less than one so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/div_addsub.sv
// (WIDTH+1)-bit add/subtract built as a full-adder ripple chain.
// Subtraction inverts operand b and injects the carry-in; the final carry-out is dropped.
module div_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] i_a,
   input  logic [WIDTH:0] i_b,
   input  logic           i_sub,
   output logic [WIDTH:0] o_sum
);

   logic [WIDTH:0] w_bx;
   logic [WIDTH:0] w_carry;

   assign w_carry[0] = i_sub;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
      assign w_bx[i]  = i_b[i] ^ i_sub;
      assign o_sum[i] = i_a[i] ^ w_bx[i] ^ w_carry[i];
      if (i < WIDTH) begin : g_carry
         assign w_carry[i+1] = (i_a[i] & w_bx[i]) | (w_carry[i] & (i_a[i] ^ w_bx[i]));
      end
   end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider: one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncation toward zero).
module nonrestoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = clog2(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH:0]   r_P;
   logic [WIDTH-1:0] r_A;
   logic [WIDTH-1:0] r_D;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_addA;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_fixP;
   logic             w_sub;
   logic [WIDTH-1:0] w_magN;
   logic [WIDTH-1:0] w_magD;
   logic [WIDTH-1:0] w_qOut;
   logic [WIDTH-1:0] w_rOut;

   // The single adder shifts-and-adds in RUN and applies the final correction in FIX.
   assign w_addA = (r_state == FIX) ? r_P : {r_P[WIDTH-1:0], r_A[WIDTH-1]};
   assign w_sub  = (r_state == FIX) ? 1'b0 : ~r_P[WIDTH];
   assign w_fixP = r_P[WIDTH] ? w_sum : r_P;

   div_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_a   (w_addA),
      .i_b   ({1'b0, r_D}),
      .i_sub (w_sub),
      .o_sum (w_sum)
   );

`ifdef SIGNED_DIV_EN
   logic r_negN;
   logic r_negD;

   assign w_magN = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_magD = divisor[WIDTH-1]  ? -divisor  : divisor;
   assign w_qOut = (r_negN ^ r_negD) ? -r_A : r_A;
   assign w_rOut = r_negN ? -w_fixP[WIDTH-1:0] : w_fixP[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_negN <= 1'b0;
         r_negD <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_negN <= dividend[WIDTH-1];
         r_negD <= divisor[WIDTH-1];
      end
   end
`else
   assign w_magN = dividend;
   assign w_magD = divisor;
   assign w_qOut = r_A;
   assign w_rOut = w_fixP[WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (start) w_next = (divisor == '0) ? DONE : RUN;
         RUN:  if (r_cnt == '0) w_next = FIX;
         FIX:  w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
      done = (r_state == DONE);
   end

   // Divide-by-zero results are loaded at acceptance so they are valid alongside done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_P         <= '0;
         r_A         <= '0;
         r_D         <= '0;
         r_cnt       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_A   <= w_magN;
                  r_D   <= w_magD;
                  r_P   <= '0;
                  r_cnt <= CW'(WIDTH - 1);
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_P   <= w_sum;
               r_A   <= {r_A[WIDTH-2:0], ~w_sum[WIDTH]};
               r_cnt <= r_cnt - 1'b1;
            end
            FIX: begin
               r_P         <= w_fixP;
               quotient    <= w_qOut;
               remainder   <= w_rOut;
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: a latency/arithmetic model checked every
// cycle plus directed vectors with literal results. Define SIGNED_DIV_EN for signed vectors.
module tb_nonrestoring_divider;

   localparam int W       = 32;
   localparam int LAT_RUN = W + 2;

   logic         clk;
   logic         rstN;
   logic         start;
   logic [W-1:0] dividendIn;
   logic [W-1:0] divisorIn;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         divByZero;

   int checkCount;
   int passCount;

   nonrestoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rstN),
      .start       (start),
      .dividend    (dividendIn),
      .divisor     (divisorIn),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (divByZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain arithmetic reference for one division.
   function automatic logic [W-1:0] modelQ(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return '1;
`ifdef SIGNED_DIV_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return a;
      return $signed(a) / $signed(b);
`else
      return a / b;
`endif
   endfunction

   function automatic logic [W-1:0] modelR(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return a;
`ifdef SIGNED_DIV_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return '0;
      return $signed(a) % $signed(b);
`else
      return a % b;
`endif
   endfunction

   // Model: cycles left until the handshake returns to idle, and the visible results.
   int           mRemain;
   logic [W-1:0] mQ, mR, pendQ, pendR;
   logic         mZ;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mRemain <= 0;
         mQ      <= '0;
         mR      <= '0;
         mZ      <= 1'b0;
         pendQ   <= '0;
         pendR   <= '0;
      end else if (mRemain == 0) begin
         if (start) begin
            if (divisorIn == 0) begin
               mRemain <= 1;
               mQ      <= '1;
               mR      <= dividendIn;
               mZ      <= 1'b1;
            end else begin
               mRemain <= LAT_RUN;
               pendQ   <= modelQ(dividendIn, divisorIn);
               pendR   <= modelR(dividendIn, divisorIn);
            end
         end
      end else begin
         mRemain <= mRemain - 1;
         if (mRemain == 2) begin
            mQ <= pendQ;
            mR <= pendR;
            mZ <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Every cycle the DUT must agree with the model.
   always @(negedge clk) begin
      checkOutput("model busy", W'(busy), W'(mRemain != 0));
      checkOutput("model done", W'(done), W'(mRemain == 1));
      checkOutput("model quotient", quotient, mQ);
      checkOutput("model remainder", remainder, mR);
      checkOutput("model div_by_zero", W'(divByZero), W'(mZ));
   end

   task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividendIn = a;
      divisorIn  = b;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Latency 1 means done is visible right after the accepting edge.
   task automatic waitDone(input int injectAt, output int lat);
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == injectAt) begin
            dividendIn = 3;
            divisorIn  = 1;
            start      = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] expQ, input logic [W-1:0] expR,
                                input logic expZ, input int expLat, input int injectAt);
      int lat;
      startOp(a, b);
      waitDone(injectAt, lat);
      checkOutput({name, " latency"}, W'(lat), W'(expLat));
      checkOutput({name, " quotient"}, quotient, expQ);
      checkOutput({name, " remainder"}, remainder, expR);
      checkOutput({name, " div_by_zero"}, W'(divByZero), W'(expZ));
   endtask

   initial begin
      int sawDone;
      checkCount = 0;
      passCount  = 0;
      start      = 1'b0;
      dividendIn = '0;
      divisorIn  = '0;
      rstN       = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", W'(busy), '0);
      checkOutput("reset done", W'(done), '0);
      checkOutput("reset quotient", quotient, '0);
      checkOutput("reset remainder", remainder, '0);
      checkOutput("reset div_by_zero", W'(divByZero), '0);
      rstN = 1'b1;

      applyStimulus("100/7", 100, 7, 14, 2, 1'b0, LAT_RUN, 0);
      applyStimulus("max/1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, LAT_RUN, 0);
      applyStimulus("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b0, LAT_RUN, 0);
      applyStimulus("5/9", 5, 9, 0, 5, 1'b0, LAT_RUN, 0);
      applyStimulus("0/3", 0, 3, 0, 0, 1'b0, LAT_RUN, 0);
      applyStimulus("1234/0", 1234, 0, 32'hFFFF_FFFF, 1234, 1'b1, 1, 0);
      applyStimulus("10/5", 10, 5, 2, 0, 1'b0, LAT_RUN, 0);

      // A start during the done cycle must be dropped.
      dividendIn = 9;
      divisorIn  = 3;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start in DONE ignored", W'(busy), '0);

      applyStimulus("100/7 with start while busy", 100, 7, 14, 2, 1'b0, LAT_RUN, 10);

      // Abort a run part-way through with reset.
      startOp(1000, 3);
      repeat (13) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("abort busy", W'(busy), '0);
      checkOutput("abort quotient", quotient, '0);
      checkOutput("abort remainder", remainder, '0);
      @(negedge clk);
      #2 rstN = 1'b1;
      sawDone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) sawDone++;
      end
      checkOutput("no done after abort", W'(sawDone), '0);

      applyStimulus("50/6", 50, 6, 8, 2, 1'b0, LAT_RUN, 0);

`ifdef SIGNED_DIV_EN
      applyStimulus("-7/2", 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_RUN, 0);
      applyStimulus("7/-2", 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 1'b0, LAT_RUN, 0);
      applyStimulus("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0, LAT_RUN, 0);
`endif

      @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
- Sequential unsigned integer divider that computes quotient and remainder using the non-restoring add/subtract algorithm, producing one quotient bit per clock.
- It is the inverse operation of the team's 32-bit ripple/carry-skip adder datapath and reuses the 33-bit (WIDTH+1) add/subtract path reserved for division.
- It sits beside the adder in the arithmetic unit and uses a start/done handshake toward the control FSM.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits. The partial remainder is WIDTH+1 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  WIDTH  numerator; captured on the accepted start.
- divisor  in  WIDTH  denominator; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when results become valid.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- div_by_zero  out  1  set with done when divisor==0; held like the results.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0; internal P, A, D and counter cleared.
  - Reset asserted mid-operation aborts the division immediately and no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1:
  - Capture A=dividend, D=divisor; P=0; cnt=WIDTH-1.
  - If divisor==0, go to DONE. Otherwise go to RUN.
- RUN, one iteration per cycle:
  - S={P[WIDTH-1:0],A[WIDTH-1]}.
  - P = P[WIDTH]==0 ? S-{1'b0,D} : S+{1'b0,D}.
  - A={A[WIDTH-2:0], ~P_new[WIDTH]}.
  - cnt decrements each cycle; after the cnt==0 iteration, go to FIX. RUN lasts exactly WIDTH cycles.
- FIX:
  - If P[WIDTH]==1, then P=P+D.
  - quotient<=A; remainder<=P[WIDTH-1:0]; div_by_zero<=0; go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - On the divide-by-zero path: quotient<={WIDTH{1'b1}}, remainder<=captured dividend, div_by_zero<=1.
- Latency:
  - Normal path: done is high WIDTH+2 cycles after the accepting edge (34 for WIDTH=32).
  - Divide-by-zero path: 1 cycle.
- busy=1 in RUN, FIX and DONE; busy=0 in IDLE.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle as done (DONE state) is ignored. It is accepted one cycle later in IDLE.
- Arithmetic:
  - All add/subtract is WIDTH+1 bits, two's complement, and the carry-out is discarded.
  - Subtraction is implemented as operand inversion plus cin=1.
- Edge cases:
  - dividend<divisor gives q=0, r=dividend.
  - dividend==divisor gives q=1, r=0.
  - Outputs change only in FIX or in DONE of the divide-by-zero path.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement. Magnitudes are captured in IDLE and the sign flags are registered.
  - In FIX, quotient is negated if the operand signs differ, and remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / -1 gives q=most-negative, r=0.
  - Divide by zero gives q=all-ones, r=dividend.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, RUN, FIX, DONE).
  - DIV_WIDTH_DEFAULT=32.
  - Counter width function clog2(WIDTH).
- One sub-module: div_addsub.
  - WIDTH+1 add/subtract built as a full-adder ripple chain.
  - Operand XOR with a sub control bit, with cin=sub.
  - Instantiated once; used in RUN for the iteration and in FIX for the correction.

Test Plan:
- Basic division: 100/7 with start for one cycle -> done exactly 34 cycles later; q=14, r=2, div_by_zero=0; busy high for 34 cycles.
- Maximum dividend: 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0. Then 0xFFFFFFFF/0xFFFFFFFF -> q=1, r=0.
- Dividend smaller than divisor: 5/9 -> q=0, r=5. 0/3 -> q=0, r=0.
- Divide by zero: 1234/0 -> done 1 cycle after acceptance; q=0xFFFFFFFF, r=1234, div_by_zero=1. A following 10/5 clears div_by_zero and gives q=2.
- Handshake and reset:
  - start pulsed at cycle 10 during busy -> ignored; results match the first operation.
  - rst_n low at cycle 15 of a run -> all outputs 0 at once and no done.
  - A new 50/6 after reset -> q=8, r=2.
- With SIGNED_DIV_EN:
  - -7/2 -> q=-3, r=-1.
  - 7/-2 -> q=-3, r=1.
  - 0x80000000/-1 -> q=0x80000000, r=0.
